// File: rtl/nes_joypad_pkg.sv
// Shared definitions for the NES joypad reader: button bit positions and FSM states.
package nes_joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the pad data line; resets to 1 so an idle line reads as released.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nes_joypad_reader.sv
// Serial NES/SNES joypad reader: periodic or on-demand poll, publishes an active-high button word per frame.
//   state | meaning
//   IDLE  | waiting for poll tick, poll_req or pending request
//   LATCH | joy_latch high, pad loads its button state
//   HIGH  | joy_clk high; current bit sampled at the end of the phase
//   LOW   | joy_clk low; pad advances to the next bit on the following rise
//   DONE  | buttons just updated, valid pulses
module nes_joypad_reader
  import nes_joypad_pkg::*;
#(
  parameter int unsigned C_clk_hz   = 21428571,
  parameter int unsigned C_poll_hz  = 60,
  parameter int unsigned C_latch_us = 12,
  parameter int unsigned C_half_us  = 6,
  parameter int unsigned C_num_bits = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  joy_latch,
  output logic                  joy_clk,
  input  logic                  joy_data,
  input  logic                  poll_req,
  output logic [C_num_bits-1:0] buttons,
  output logic                  valid,
  output logic                  busy
);

  localparam logic [63:0] LATCH_CYC = (64'(C_clk_hz) * 64'(C_latch_us)) / 64'd1000000;
  localparam logic [63:0] HALF_CYC  = (64'(C_clk_hz) * 64'(C_half_us)) / 64'd1000000;
  localparam logic [63:0] T_LATCH   = (LATCH_CYC == 64'd0) ? 64'd1 : LATCH_CYC;
  localparam logic [63:0] T_HALF    = (HALF_CYC == 64'd0) ? 64'd1 : HALF_CYC;
  localparam logic [63:0] T_POLL    = (C_poll_hz == 0) ? 64'd1 : 64'(C_clk_hz) / 64'(C_poll_hz);
  localparam logic [63:0] T_PH_MAX  = (T_LATCH > T_HALF) ? T_LATCH : T_HALF;

  localparam int PH_W   = (T_PH_MAX > 64'd1) ? $clog2(T_PH_MAX) : 1;
  localparam int POLL_W = (T_POLL > 64'd1) ? $clog2(T_POLL) : 1;
  localparam int BIT_W  = (C_num_bits > 1) ? $clog2(C_num_bits) : 1;

  localparam logic [PH_W-1:0]   LATCH_LOAD = PH_W'(T_LATCH - 64'd1);
  localparam logic [PH_W-1:0]   HALF_LOAD  = PH_W'(T_HALF - 64'd1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(T_POLL - 64'd1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(C_num_bits - 1);

  state_e                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [C_num_bits-1:0]   shift_q, shift_d;
  logic [C_num_bits-1:0]   buttons_q, buttons_d;
  logic [POLL_W-1:0]       timer_q, timer_d;
  logic                    pending_q, pending_d;
  logic                    s_data;
  logic                    tick;
  logic                    req;

  sync2 u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (joy_data),
    .q       (s_data)
  );

  always_comb begin
    tick      = (C_poll_hz != 0) && (timer_q == POLL_LAST);
    req       = tick | poll_req;
    timer_d   = tick ? '0 : timer_q + POLL_W'(1);
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    pending_d = pending_q;

    // Requests arriving mid-frame collapse into a single follow-up frame.
    if (state_q != IDLE && req) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (req || pending_q) begin
          state_d   = LATCH;
          phase_d   = LATCH_LOAD;
          bit_d     = '0;
          shift_d   = '0;
          pending_d = 1'b0;
        end
      end
      LATCH: begin
        if (phase_q == '0) begin
          state_d = HIGH;
          phase_d = HALF_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      HIGH: begin
        if (phase_q == '0) begin
          shift_d[bit_q] = s_data;
          if (bit_q == LAST_BIT) begin
            state_d   = DONE;
            buttons_d = ~shift_d;
          end else begin
            state_d = LOW;
            phase_d = HALF_LOAD;
          end
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          state_d = HIGH;
          phase_d = HALF_LOAD;
          bit_d   = bit_q + BIT_W'(1);
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign joy_latch = (state_q == LATCH);
  assign joy_clk   = (state_q != LOW);
  assign valid     = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign buttons   = buttons_q;

endmodule

// File: tb/tb_nes_joypad_reader.sv
// Bench for nes_joypad_reader: frame-timeline model for the 8-bit reader plus directed literal checks.
module tb_nes_joypad_reader;
  import nes_joypad_pkg::*;

  localparam int T_POLL  = 16666;
  localparam int T_LATCH = 12;
  localparam int T_HALF  = 6;
  localparam int L8      = T_LATCH + 15 * T_HALF + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic poll8 = 1'b0, poll16 = 1'b0;
  logic jl8, jc8, jd8, v8, b8;
  logic [7:0] btn8;
  logic jl16, jc16, jd16, v16, b16;
  logic [15:0] btn16;

  nes_joypad_reader #(.C_clk_hz(1000000), .C_poll_hz(60), .C_latch_us(12), .C_half_us(6), .C_num_bits(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .joy_latch(jl8), .joy_clk(jc8), .joy_data(jd8),
    .poll_req(poll8), .buttons(btn8), .valid(v8), .busy(b8));

  nes_joypad_reader #(.C_clk_hz(1000000), .C_poll_hz(0), .C_latch_us(12), .C_half_us(6), .C_num_bits(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .joy_latch(jl16), .joy_clk(jc16), .joy_data(jd16),
    .poll_req(poll16), .buttons(btn16), .valid(v16), .busy(b16));

  // Pad models: parallel load on latch, shift toward bit0 on each joy_clk rise.
  int          pad_mode = 0;
  logic [7:0]  press8 = 8'h00;
  logic [15:0] press16 = 16'h0000;
  logic [7:0]  sr8 = 8'hFF;
  logic [15:0] sr16 = 16'hFFFF;

  always @(posedge jl8 or posedge jc8)
    if (jl8) sr8 <= ~press8; else sr8 <= {1'b1, sr8[7:1]};
  always @(posedge jl16 or posedge jc16)
    if (jl16) sr16 <= ~press16; else sr16 <= {1'b1, sr16[15:1]};

  assign jd8  = (pad_mode == 1) ? 1'b1 : (pad_mode == 2) ? 1'b0 : sr8[0];
  assign jd16 = sr16[0];

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a frame is just an age counter since its first latch cycle.
  bit         m_on = 1'b0;
  bit         m_active = 1'b0, m_pend = 1'b0;
  int         m_age = 0, m_t = 0;
  logic [7:0] m_btn = 8'h00;

  function automatic logic [7:0] pad_result8();
    case (pad_mode)
      1:       return 8'h00;
      2:       return 8'hFF;
      default: return press8;
    endcase
  endfunction

  function automatic bit exp_clk(input bit active, input int age);
    int k;
    if (!active || age < T_LATCH) return 1'b1;
    k = age - T_LATCH;
    if (k >= 15 * T_HALF) return 1'b1;
    return ((k / T_HALF) % 2) == 0;
  endfunction

  always @(negedge clk) begin
    bit req;
    if (m_on) begin
      check("m_busy",   32'(b8),   32'(m_active));
      check("m_latch",  32'(jl8),  32'(m_active && m_age < T_LATCH));
      check("m_clk",    32'(jc8),  32'(exp_clk(m_active, m_age)));
      check("m_valid",  32'(v8),   32'(m_active && m_age == L8 - 1));
      check("m_btn",    32'(btn8), 32'(m_btn));
    end
    if (!reset_n) begin
      m_active = 1'b0; m_pend = 1'b0; m_age = 0; m_t = 0; m_btn = 8'h00; m_on = 1'b1;
    end else begin
      req = poll8 || (m_t == T_POLL - 1);
      m_t = (m_t == T_POLL - 1) ? 0 : m_t + 1;
      if (m_active) begin
        if (req) m_pend = 1'b1;
        if (m_age == L8 - 1) m_active = 1'b0;
        else begin
          m_age++;
          if (m_age == L8 - 1) m_btn = pad_result8();
        end
      end else if (req || m_pend) begin
        m_active = 1'b1; m_age = 0; m_pend = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the frame's valid cycle.
  task automatic poll_frame(input bit sel16, output int busy_n, output int valid_at,
                            output int rises, output int latch_hi);
    bit prev_c, c_now;
    if (sel16) poll16 = 1'b1; else poll8 = 1'b1;
    @(posedge clk); #1;
    poll8 = 1'b0; poll16 = 1'b0;
    busy_n = 0; valid_at = 0; rises = 0; latch_hi = 0; prev_c = 1'b1;
    for (int c = 1; c <= 400 && valid_at == 0; c++) begin
      @(negedge clk);
      c_now = sel16 ? jc16 : jc8;
      if (sel16 ? b16 : b8) busy_n++;
      if (sel16 ? jl16 : jl8) latch_hi++;
      if (c_now && !prev_c) rises++;
      prev_c = c_now;
      if (sel16 ? v16 : v8) valid_at = c;
    end
    if (valid_at == 0) check("frame_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, va, ri, lh, nval, t1, t2, cyc, lat1;
    bit prev_l;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_latch", 32'(jl8), 32'd0);
    check("rst_clk",   32'(jc8), 32'd1);
    check("rst_btn",   32'(btn8), 32'd0);
    check("rst_valid", 32'(v8), 32'd0);
    check("rst_busy",  32'(b8), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    press8 = 8'((1 << BTN_A) | (1 << BTN_START));
    poll_frame(1'b0, bn, va, ri, lh);
    check("a_start_btn",   32'(btn8), 32'h09);
    check("a_start_valid", 32'(va), 32'd103);
    check("a_start_busy",  32'(bn), 32'd103);
    check("a_start_rises", 32'(ri), 32'd7);
    check("a_start_latch", 32'(lh), 32'd12);

    repeat (3) @(posedge clk); #1;
    pad_mode = 1;
    poll_frame(1'b0, bn, va, ri, lh);
    check("unplugged_btn", 32'(btn8), 32'h00);
    check("unplugged_valid", 32'(va), 32'd103);
    pad_mode = 2;
    poll_frame(1'b0, bn, va, ri, lh);
    check("shorted_btn", 32'(btn8), 32'hFF);
    pad_mode = 0;
    press8 = 8'((1 << BTN_B) | (1 << BTN_UP) | (1 << BTN_RIGHT));
    poll_frame(1'b0, bn, va, ri, lh);
    check("b_up_right_btn", 32'(btn8), 32'h92);

    press16 = 16'hA5C3;
    poll_frame(1'b1, bn, va, ri, lh);
    check("snes_btn",   32'(btn16), 32'hA5C3);
    check("snes_valid", 32'(va), 32'd199);
    check("snes_busy",  32'(bn), 32'd199);
    check("snes_rises", 32'(ri), 32'd15);

    // Three requests during one frame -> exactly one follow-up frame.
    nval = 0;
    for (int c = 0; c < 300; c++) begin
      poll8 = (c == 0 || c == 10 || c == 30 || c == 80);
      @(negedge clk);
      if (v8) nval++;
      @(posedge clk); #1;
    end
    poll8 = 1'b0;
    check("merged_frames", 32'(nval), 32'd2);

    // Poll request landing on the autonomous tick -> one frame.
    for (int c = 0; c < 20000 && m_t != T_POLL - 1; c++) begin
      @(posedge clk); #1;
    end
    check("tick_align", 32'(m_t), 32'(T_POLL - 1));
    poll8 = 1'b1;
    @(posedge clk); #1;
    poll8 = 1'b0;
    nval = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (v8) nval++;
    end
    check("tick_poll_frames", 32'(nval), 32'd1);

    // Free-running polls: latch rises one poll period apart.
    t1 = -1; t2 = -1; cyc = 0; prev_l = jl8; lat1 = 0;
    while (t2 < 0 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (jl8 && !prev_l) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
      if (jl8 && t1 >= 0 && t2 < 0) lat1++;
      prev_l = jl8;
    end
    check("free_run_found", 32'(t2 >= 0), 32'd1);
    check("free_run_period", 32'(t2 - t1), 32'(T_POLL));
    check("free_run_latch", 32'(lat1), 32'd12);
    repeat (200) @(posedge clk); #1;

    // Reset in the middle of a frame.
    press8 = 8'h09;
    poll_frame(1'b0, bn, va, ri, lh);
    check("pre_reset_btn", 32'(btn8), 32'h09);
    poll8 = 1'b1;
    @(posedge clk); #1;
    poll8 = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_latch", 32'(jl8), 32'd0);
    check("midrst_clk",   32'(jc8), 32'd1);
    check("midrst_btn",   32'(btn8), 32'd0);
    check("midrst_busy",  32'(b8), 32'd0);
    check("midrst_valid", 32'(v8), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    nval = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (v8) nval++;
    end
    check("post_rst_valid", 32'(nval), 32'd0);
    check("post_rst_btn", 32'(btn8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
